button_event_ctrl: RTL and testbench

//  Avalon-MM slave controller for the board push-buttons. It replaces raw polling of the button lines.
//  Per button: input sync, debounce, press-polarity normalisation, press-edge capture, maskable irq.

---
 rtl/button_event_ctrl_if.sv | 18 +
 rtl/button_event_ctrl.sv | 150 +++++++++++++++
 tb/tb_button_event_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Avalon-MM slave bus bundle for button_event_ctrl.
//   address   [1:0]  register select
//   read             read strobe (no side effects)
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] registered read data
//   irq              level interrupt request
interface button_event_ctrl_if;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport slave  (input  address, read, write, writedata, output readdata, irq);
   modport master (output address, read, write, writedata, input  readdata, irq);
endinterface

// File: rtl/button_event_ctrl.sv
// Push-button event controller, Avalon-MM slave.
// Per button: 2-FF sync, polarity normalisation (1 = pressed), debounce,
// press-edge capture, maskable level irq.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  raw button pins (asynchronous)
//   bus      Avalon-MM slave (address/read/write/writedata/readdata/irq)
// Registers: 0 STATE (RO), 1 MASK (RW), 2 EDGE (W1C), 3 COUNT (RO, write clears).

// One debounce lane. level is the accepted (debounced) value; press pulses
// on the same clock that level commits 0->1.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic norm,
   output logic level,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, COUNT} db_state_t;

   db_state_t     st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          level_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st    <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         st    <= st_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
      end
   end

   always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      level_nxt = level;
      press     = 1'b0;
      case (st)
         IDLE: begin
            if (norm != level) begin
               st_nxt  = COUNT;
               cnt_nxt = CW'(1);
            end
         end
         COUNT: begin
            if (norm == level) begin
               // input fell back before the hold time: glitch rejected
               st_nxt  = IDLE;
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               level_nxt = norm;
               st_nxt    = IDLE;
               cnt_nxt   = '0;
               press     = norm;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
         end
      endcase
   end
endmodule

module button_event_ctrl #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    in_port,
   button_event_ctrl_if.slave  bus
);
   // pin level of a released button; sync stages reset here so no false
   // press is seen coming out of reset
   localparam logic [WIDTH-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [1:0][WIDTH-1:0] sync_pipe;
   logic [WIDTH-1:0]      norm, state, press, mask, edge_q;
   logic [7:0]            count, press_cnt;
   logic [31:0]           rd_mux;
   logic                  wr_mask, wr_edge, wr_count;
   logic                  unused_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_pipe <= {2{REL_LVL}};
      else          sync_pipe <= {sync_pipe[0], in_port};
   end

   assign norm = sync_pipe[1] ^ REL_LVL;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [WIDTH-1:0] (
      .clk     (clk),
      .reset_n (reset_n),
      .norm    (norm),
      .level   (state),
      .press   (press)
   );

   always_comb begin
      press_cnt = '0;
      for (int i = 0; i < WIDTH; i++) press_cnt = press_cnt + 8'(press[i]);
   end

   assign wr_mask  = bus.write && (bus.address == 2'd1);
   assign wr_edge  = bus.write && (bus.address == 2'd2);
   assign wr_count = bus.write && (bus.address == 2'd3);

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0:    rd_mux[WIDTH-1:0] = state;
         2'd1:    rd_mux[WIDTH-1:0] = mask;
         2'd2:    rd_mux[WIDTH-1:0] = edge_q;
         default: rd_mux[7:0]       = count;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask         <= '0;
         edge_q       <= '0;
         count        <= '0;
         bus.irq      <= 1'b0;
         bus.readdata <= '0;
      end else begin
         if (wr_mask) mask <= bus.writedata[WIDTH-1:0];
         // clear applied first so a same-cycle press wins
         edge_q       <= (edge_q & ~(wr_edge ? bus.writedata[WIDTH-1:0] : '0)) | press;
         count        <= (wr_count ? 8'd0 : count) + press_cnt;
         bus.irq      <= |(edge_q & mask);
         bus.readdata <= rd_mux;
      end
   end

   assign unused_ok = &{1'b0, bus.read, bus.writedata};
endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed + randomized bench for button_event_ctrl (WIDTH=4, DEBOUNCE=8,
// active-low pins). A windowed reference model predicts readdata/irq each cycle.
module tb_button_event_ctrl;
   localparam int DB = 8;

   logic       clk;
   logic       reset_n;
   logic [3:0] in_port;
   int         errors = 0;
   int         checks = 0;

   button_event_ctrl_if bus();

   button_event_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: state flips once the pressed-level (pin delayed by the
   // two sync clocks) has disagreed with it for DB consecutive samples
   logic [3:0]  pin_hist[$];
   logic [3:0]  nhist[$];
   logic [3:0]  m_state, m_mask, m_edge;
   logic [7:0]  m_count;
   logic [31:0] m_rd;
   logic        m_irq;

   task automatic model_reset();
      pin_hist = {4'hF, 4'hF};
      nhist    = {};
      m_state  = '0; m_mask = '0; m_edge = '0; m_count = '0;
      m_rd     = '0; m_irq = 1'b0;
   endtask

   task automatic model_edge();
      logic [3:0]  n, nst, prs;
      logic [31:0] rdv;
      bit          alld;
      if (!reset_n) begin
         model_reset();
         return;
      end
      n = ~pin_hist.pop_front();
      pin_hist.push_back(in_port);
      nhist.push_back(n);
      if (nhist.size() > DB) void'(nhist.pop_front());
      nst = m_state;
      prs = '0;
      if (nhist.size() == DB) begin
         for (int i = 0; i < 4; i++) begin
            alld = 1'b1;
            foreach (nhist[j]) if (nhist[j][i] == m_state[i]) alld = 1'b0;
            if (alld) begin
               nst[i] = ~m_state[i];
               prs[i] = nst[i];
            end
         end
      end
      case (bus.address)
         2'd0:    rdv = {28'd0, m_state};
         2'd1:    rdv = {28'd0, m_mask};
         2'd2:    rdv = {28'd0, m_edge};
         default: rdv = {24'd0, m_count};
      endcase
      m_rd  = rdv;
      m_irq = |(m_edge & m_mask);
      if (bus.write) begin
         if (bus.address == 2'd1) m_mask = bus.writedata[3:0];
         if (bus.address == 2'd2) m_edge = m_edge & ~bus.writedata[3:0];
         if (bus.address == 2'd3) m_count = 8'd0;
      end
      m_edge  = m_edge | prs;
      m_count = m_count + 8'($countones(prs));
      m_state = nst;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("readdata", bus.readdata, m_rd);
      chk("irq", {31'd0, bus.irq}, {31'd0, m_irq});
   endtask

   task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus.address = a;
      bus.read    = 1'b1;
      tick();
      bus.read    = 1'b0;
      chk(tag, bus.readdata, exp);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      bus.address   = a;
      bus.writedata = d;
      bus.write     = 1'b1;
      tick();
      bus.write     = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; in_port = 4'hF;
      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
      model_reset();
      repeat (3) tick();
      reset_n = 1'b1;

      // 1: reset state
      rd_reg(2'd0, 32'h0, "s1_state");
      rd_reg(2'd2, 32'h0, "s1_edge");
      rd_reg(2'd3, 32'h0, "s1_count");
      chk("s1_irq", {31'd0, bus.irq}, 32'd0);

      // 2: press bit0; state commits on the 10th clock, visible on readdata at 11
      bus.address = 2'd0;
      in_port[0]  = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 10) chk("s2_state_early", bus.readdata, 32'h0);
         if (k == 11) chk("s2_state", bus.readdata, 32'h1);
      end
      rd_reg(2'd2, 32'h1, "s2_edge");
      rd_reg(2'd3, 32'h1, "s2_count");
      chk("s2_irq", {31'd0, bus.irq}, 32'd0);

      // 3: mask then W1C
      wr_reg(2'd1, 32'h1);
      tick();
      chk("s3_irq_on", {31'd0, bus.irq}, 32'd1);
      wr_reg(2'd2, 32'h1);
      tick();
      chk("s3_irq_off", {31'd0, bus.irq}, 32'd0);
      rd_reg(2'd2, 32'h0, "s3_edge");
      rd_reg(2'd3, 32'h1, "s3_count");

      // 4: bouncing bit1, never held long enough
      for (int k = 0; k < 100; k++) begin
         if (k % 5 == 0) in_port[1] = ~in_port[1];
         tick();
      end
      for (int k = 0; k < 12; k++) begin
         in_port[1] = ~in_port[1];
         repeat ($urandom_range(1, DB - 1)) tick();
      end
      in_port[1] = 1'b1;
      repeat (12) tick();
      rd_reg(2'd0, 32'h1, "s4_state");
      rd_reg(2'd2, 32'h0, "s4_edge");
      rd_reg(2'd3, 32'h1, "s4_count");

      // 5: release bit0, re-press so the edge sets in the W1C cycle
      in_port[0] = 1'b1;
      repeat (14) tick();
      rd_reg(2'd0, 32'h0, "s5_released");
      in_port[0] = 1'b0;
      repeat (9) tick();
      wr_reg(2'd2, 32'h1);
      rd_reg(2'd2, 32'h1, "s5_edge_setwins");
      rd_reg(2'd3, 32'h2, "s5_count");
      chk("s5_irq", {31'd0, bus.irq}, 32'd1);

      // COUNT clear in the same cycle as a press
      in_port[2] = 1'b0;
      repeat (9) tick();
      wr_reg(2'd3, 32'h0);
      rd_reg(2'd3, 32'h1, "clr_with_press");
      in_port[2] = 1'b1;
      repeat (14) tick();

      // two bits pressing in the same cycle
      wr_reg(2'd3, 32'h0);
      in_port[1] = 1'b0; in_port[3] = 1'b0;
      repeat (12) tick();
      rd_reg(2'd3, 32'h2, "multi_count");
      rd_reg(2'd2, 32'hF, "multi_edge");
      in_port = 4'hF;
      repeat (14) tick();

      // 6: 256 presses wrap COUNT
      wr_reg(2'd3, 32'h0);
      for (int p = 0; p < 256; p++) begin
         in_port[2] = 1'b0;
         repeat (11) tick();
         in_port[2] = 1'b1;
         repeat (11) tick();
      end
      rd_reg(2'd3, 32'h0, "s6_wrap");

      // random pins and register traffic against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) in_port = 4'($urandom);
         bus.address   = 2'($urandom);
         bus.writedata = $urandom;
         bus.write     = ($urandom_range(0, 15) == 0);
         tick();
      end
      bus.write = 1'b0;
      in_port   = 4'hF;
      repeat (14) tick();

      // reset in the middle of a debounce count
      wr_reg(2'd1, 32'hF);
      in_port[2] = 1'b0;
      repeat (11) tick();
      bus.address = 2'd2;
      tick();
      chk("pre_rst_irq", {31'd0, bus.irq}, 32'd1);
      in_port[0] = 1'b0;
      repeat (5) tick();
      reset_n = 1'b0;
      #1;
      chk("rst_readdata", bus.readdata, 32'h0);
      chk("rst_irq", {31'd0, bus.irq}, 32'd0);
      model_reset();
      repeat (3) tick();
      reset_n = 1'b1;
      bus.address = 2'd0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 10) chk("held_early", bus.readdata, 32'h0);
         if (k == 11) chk("held_press", bus.readdata, 32'h5);
      end
      rd_reg(2'd3, 32'h2, "rst_count");
      rd_reg(2'd1, 32'h0, "rst_mask");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
